// File: rtl/ex_muldiv_unit.sv
// EX-stage operand resolution plus an iterative MUL / DIVU / REMU engine.
// Stalls the pipeline via busy_o while the 32-step shift-add or restoring-divide runs.
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      ForwardA_i,
    input  logic [1:0]      ForwardB_i,
    input  logic [XLEN-1:0] EXRs1Data_i,
    input  logic [XLEN-1:0] EXRs2Data_i,
    input  logic [XLEN-1:0] MemALUResult_i,
    input  logic [XLEN-1:0] WBWriteData_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] OpA_o,
    output logic [XLEN-1:0] OpB_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(ITER);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                start_ok;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic                div_ge;
    logic [XLEN-1:0]     div_rem;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   iter_next;

    // Forwarding mux: 10 = EX/MEM, 01 = MEM/WB, 00 and 11 = register file.
    always_comb begin
        case (ForwardA_i)
            2'b10:   OpA_o = MemALUResult_i;
            2'b01:   OpA_o = WBWriteData_i;
            default: OpA_o = EXRs1Data_i;
        endcase
        case (ForwardB_i)
            2'b10:   OpB_o = MemALUResult_i;
            2'b01:   OpB_o = WBWriteData_i;
            default: OpB_o = EXRs2Data_i;
        endcase
    end

    assign start_ok = (state_q == S_IDLE) && start_i && (op_i != OP_RSVD) && !flush_i;
    assign busy_o   = rst_i && (start_ok || (state_q == S_BUSY));
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

    // acc_q is {high, low}: for MUL the partial product with the multiplier in the low
    // half; for division the running remainder and the dividend/quotient shift register.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};

        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};

        iter_next = (op_q == OP_MUL) ? mul_next : div_next;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    op_d    = op_i;
                    b_d     = OpB_o;
                    acc_d   = {{XLEN{1'b0}}, OpA_o};
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = iter_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d  = S_DONE;
                        cnt_d    = '0;
                        result_d = (op_q == OP_REMU) ? iter_next[2*XLEN-1:XLEN]
                                                     : iter_next[XLEN-1:0];
                    end
                end
            end
            S_DONE: begin
                // The finishing instruction is still in EX this cycle, so start_i is ignored.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: stimulus pushes expected results into exp_q,
// an independent monitor pops and compares on every done_o pulse.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] rs1, rs2, mem_res, wb_data;
    logic        start, flush;
    logic [1:0]  op;
    logic [31:0] opa, opb, result;
    logic        busy, done;

    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    int          check_cnt;
    int          pass_cnt;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .ForwardA_i     (fwd_a),
        .ForwardB_i     (fwd_b),
        .EXRs1Data_i    (rs1),
        .EXRs2Data_i    (rs2),
        .MemALUResult_i (mem_res),
        .WBWriteData_i  (wb_data),
        .start_i        (start),
        .op_i           (op),
        .flush_i        (flush),
        .OpA_o          (opa),
        .OpB_o          (opb),
        .busy_o         (busy),
        .done_o         (done),
        .result_o       (result)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    // Issues an op at cycle T (called just after a rising edge) and returns just after the
    // edge that ends T+33, with start_i still asserted through DONE.
    task automatic run_op(input logic [1:0] o, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] m, input logic [31:0] w, input logic [31:0] mid_m,
                          input logic [31:0] exp_a, input logic [31:0] exp_b,
                          input logic [31:0] exp_r);
        bit bad;
        start = 1'b1; op = o; fwd_a = fa; fwd_b = fb;
        rs1 = a; rs2 = b; mem_res = m; wb_data = w;
        exp_q.push_back(exp_r);
        @(negedge clk);
        check("opa_start", opa, exp_a);
        check("opb_start", opb, exp_b);
        check("busy_start", {31'd0, busy}, 32'd1);
        bad = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (i == 3) mem_res = mid_m;
            @(negedge clk);
            if (!busy || done) bad = 1'b1;
        end
        check("busy_window", {31'd0, bad}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_done_cycle", {31'd0, busy}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd1);
        last_res = exp_r;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        start = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        check_cnt = 0; pass_cnt = 0; last_res = 32'd0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
        fwd_a = 2'b00; fwd_b = 2'b00;
        rs1 = '0; rs2 = '0; mem_res = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MUL 7*6, operand changes on MEM path mid-op must not matter
        run_op(2'b00, 2'b00, 2'b00, 32'd7, 32'd6, 32'd0, 32'd0, 32'd0, 32'd7, 32'd6, 32'd42);
        idle_cycle();
        run_op(2'b00, 2'b10, 2'b00, 32'd0, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5,
               32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        idle_cycle();
        // MUL overflow discards the high word
        run_op(2'b00, 2'b00, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 32'd0,
               32'h0001_0000, 32'h0001_0000, 32'd0);
        idle_cycle();
        // WB forwarding on B, DIVU / REMU
        run_op(2'b01, 2'b00, 2'b01, 32'd100, 32'd0, 32'd0, 32'd7, 32'd0, 32'd100, 32'd7, 32'd14);
        idle_cycle();
        run_op(2'b10, 2'b00, 2'b01, 32'd100, 32'd0, 32'd0, 32'd7, 32'd0, 32'd100, 32'd7, 32'd2);
        idle_cycle();
        // select 11 behaves as register file
        run_op(2'b01, 2'b11, 2'b01, 32'd9, 32'd0, 32'd77, 32'd7, 32'd77, 32'd9, 32'd7, 32'd1);
        idle_cycle();
        // divide by zero
        run_op(2'b01, 2'b00, 2'b00, 32'h1234, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234, 32'd0,
               32'hFFFF_FFFF);
        idle_cycle();
        run_op(2'b10, 2'b00, 2'b00, 32'h1234, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234, 32'd0,
               32'h1234);
        idle_cycle();

        // reserved op is ignored
        start = 1'b1; op = 2'b11; rs1 = 32'd3; rs2 = 32'd3;
        @(negedge clk);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("rsvd_no_capture", {31'd0, busy}, 32'd0);
        // flush in IDLE blocks start
        @(posedge clk); #1; start = 1'b1; op = 2'b00; flush = 1'b1;
        @(negedge clk);
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_no_capture", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // flush at T+10 aborts with no done and result held
        start = 1'b1; op = 2'b00; fwd_a = 2'b00; fwd_b = 2'b00; rs1 = 32'd5; rs2 = 32'd5;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1; flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush_busy_drop", {31'd0, busy}, 32'd0);
        check("flush_no_done", {31'd0, done}, 32'd0);
        check("flush_result_hold", result, last_res);
        repeat (30) @(posedge clk);
        #1;
        check("flush_result_later", result, last_res);

        // async reset at T+5 mid-cycle
        start = 1'b1; op = 2'b00; rs1 = 32'd4; rs2 = 32'd4;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_result", result, 32'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b00, 2'b00, 2'b00, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 32'd3, 32'd3, 32'd9);

        // back-to-back: start held through DONE, next op accepted right after
        idle_cycle();
        run_op(2'b00, 2'b00, 2'b00, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd2, 32'd3, 32'd6);
        run_op(2'b01, 2'b00, 2'b00, 32'd9, 32'd3, 32'd0, 32'd0, 32'd0, 32'd9, 32'd3, 32'd3);
        idle_cycle();
        repeat (40) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        check("idle_at_end", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 5-stage RISC-V pipeline, directly downstream of the forwarding unit.
- Consumes the forwarding selects and resolves both operands: register file, EX/MEM ALU result or WB write data.
- Exports the resolved operands to the single-cycle ALU.
- For MUL/DIVU/REMU, runs a 32-iteration sequential engine and holds the pipeline with a stall request until the result is ready.

Parameters:
- XLEN, 32, datapath width.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- ForwardA_i  input  2  rs1 operand select from forwarding unit
- ForwardB_i  input  2  rs2 operand select from forwarding unit
- EXRs1Data_i  input  XLEN  rs1 value from ID/EX register
- EXRs2Data_i  input  XLEN  rs2 value from ID/EX register
- MemALUResult_i  input  XLEN  ALU result in EX/MEM register
- WBWriteData_i  input  XLEN  write-back data in MEM/WB stage
- start_i  input  1  EX instruction is a mul/div op
- op_i  input  2  00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 reserved
- flush_i  input  1  EX instruction squashed
- OpA_o  output  XLEN  resolved rs1 operand, to ALU
- OpB_o  output  XLEN  resolved rs2 operand, to ALU
- busy_o  output  1  stall request to hazard/pipeline control
- done_o  output  1  result valid pulse
- result_o  output  XLEN  mul/div result

Behaviour:
- Operand mux (combinational):
  - select 00 -> EXRs*Data_i; 10 -> MemALUResult_i; 01 -> WBWriteData_i.
  - select 11 is treated as 00.
  - Applies independently to A and B.
- FSM states: IDLE, BUSY, DONE.
- Reset (rst_i low, any time, including mid-operation):
  - state=IDLE, iteration counter=0, result_o=0, done_o=0, internal accumulators=0.
  - busy_o=0 while in reset.
- IDLE:
  - If start_i=1, op_i!=11 and flush_i=0: capture OpA_o/OpB_o and op_i into internal registers, counter=0, next state BUSY.
  - op_i=11 with start_i=1: no action, busy_o stays 0.
- busy_o = (IDLE & start_i & op_i!=11 & !flush_i) | BUSY.
  - The stall is asserted combinationally in the start cycle, so the instruction does not leave EX.
- BUSY:
  - One iteration per cycle. Counter increments; after iteration ITER-1, next state is DONE.
  - MUL: shift-add, multiplier LSB first, 2*XLEN partial product. Result is the low XLEN bits.
  - DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
- DONE:
  - done_o=1 and result_o valid for exactly one cycle; busy_o=0 so the pipeline advances.
  - Next state IDLE unconditionally. start_i is ignored in DONE, because the same instruction is still in EX.
- Latency: start sampled at cycle T -> busy_o high cycles T..T+32 (33 cycles) -> done_o at T+33.
- Operand capture: operands are latched once at start. Changes on data or forward inputs during BUSY have no effect on the result.
- result_o holds its last value until the next DONE. It is not cleared by flush.
- Divide by zero (captured B=0), same latency, no special state:
  - DIVU -> 0xFFFFFFFF.
  - REMU -> dividend.
- Overflow: MUL discards the high XLEN bits. Unsigned division has no overflow case.
- flush_i:
  - In BUSY: return to IDLE next cycle, no done_o, result_o unchanged, busy_o deasserts the cycle after flush.
  - In IDLE: blocks start.
  - In DONE: no effect.
- Back-to-back: a new start_i is accepted in the IDLE cycle immediately following DONE.

Test Plan:
- MUL, ForwardA=ForwardB=00, EXRs1Data=7, EXRs2Data=6, start at T -> busy_o 1 for T..T+32, done_o=1 and result_o=42 at T+33, busy_o=0 at T+33.
- MUL, ForwardA=10, MemALUResult=0xFFFFFFFF, EXRs2Data=2 -> OpA_o=0xFFFFFFFF in start cycle; result_o=0xFFFFFFFE. Changing MemALUResult to 5 at T+3 leaves the result unchanged.
- ForwardB=01, WBWriteData=7, EXRs1Data=100:
  - DIVU -> result_o=14.
  - REMU -> result_o=2.
  - Select 11 on A with EXRs1Data=9 -> OpA_o=9.
- Divide by zero, B=0, A=0x1234:
  - DIVU -> result_o=0xFFFFFFFF.
  - REMU -> result_o=0x1234.
  - Both at T+33.
- Abort paths:
  - flush_i at T+10 -> busy_o=0 from T+11, no done_o, result_o keeps its prior value.
  - rst_i low at T+5 (async, mid-clock) -> busy_o, done_o, result_o=0 immediately.
  - After release, a new MUL 3*3 -> 9.
- Back-to-back MUL 2*3 then DIVU 9/3 -> done_o at T+33 (6) and again 34 cycles later (3); no start captured during DONE.
